seven_seg_scan_driver: RTL and testbench

SEVEN_SEG_SCAN_DRIVER -- requirements
Module: seven_seg_scan_driver

---
 rtl/seven_seg_pkg.sv | 18 +
 rtl/seven_seg_font.sv | 11 +
 rtl/seven_seg_scan_driver.sv | 150 +++++++++++++++
 tb/tb_seven_seg_scan_driver.sv | 208 ++++++++++++++++++++
 4 files changed

// File: rtl/seven_seg_pkg.sv
// Shared constants and hex font for the seven-segment scan driver.
// Segment bit order is gfedcba (bit0 = a), active-high.
package seven_seg_pkg;

  localparam int SEG_W = 7;

  localparam logic [SEG_W-1:0] FONT [16] = '{
    7'h3F, 7'h06, 7'h5B, 7'h4F,
    7'h66, 7'h6D, 7'h7D, 7'h07,
    7'h7F, 7'h6F, 7'h77, 7'h7C,
    7'h39, 7'h5E, 7'h79, 7'h71
  };

  function automatic logic [SEG_W-1:0] hex_to_seg(input logic [3:0] nib);
    return FONT[nib];
  endfunction

endpackage

// File: rtl/seven_seg_font.sv
// Combinational hex nibble to active-high gfedcba segment decoder.
module seven_seg_font
  import seven_seg_pkg::*;
(
  input  logic [3:0]       nibble,
  output logic [SEG_W-1:0] seg
);

  assign seg = hex_to_seg(nibble);

endmodule

// File: rtl/seven_seg_scan_driver.sv
// Multiplexed seven-segment scan driver with frame-synchronous display update.
// Optional leading-zero blanking is enabled by defining SEVEN_SEG_LZB_EN.
module seven_seg_scan_driver
  import seven_seg_pkg::*;
#(
  parameter int NUM_DIGITS     = 4,
  parameter int SCAN_DIV       = 50000,
  parameter int SEG_ACTIVE_LOW = 0,
  parameter int AN_ACTIVE_LOW  = 1
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic                    load,
  input  logic [4*NUM_DIGITS-1:0] value,
  input  logic [NUM_DIGITS-1:0]   dp_in,
  input  logic                    blank,
  output logic [SEG_W-1:0]        seg,
  output logic                    dp,
  output logic [NUM_DIGITS-1:0]   an,
  output logic                    frame_tick
);

  localparam int VAL_W = 4 * NUM_DIGITS;
  localparam int PRE_W = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
  localparam int IDX_W = (NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1;

  localparam logic [PRE_W-1:0]      PRE_LAST = PRE_W'(SCAN_DIV - 1);
  localparam logic [IDX_W-1:0]      IDX_LAST = IDX_W'(NUM_DIGITS - 1);
  localparam logic [SEG_W-1:0]      SEG_OFF  = (SEG_ACTIVE_LOW != 0) ? '1 : '0;
  localparam logic                  DP_OFF   = (SEG_ACTIVE_LOW != 0);
  localparam logic [NUM_DIGITS-1:0] AN_OFF   = (AN_ACTIVE_LOW != 0) ? '1 : '0;

  logic [PRE_W-1:0]      presc;
  logic [IDX_W-1:0]      digit_idx;
  logic                  scan_wrap;
  logic                  frame_wrap;

  logic [VAL_W-1:0]      shadow_val;
  logic [NUM_DIGITS-1:0] shadow_dp;
  logic [VAL_W-1:0]      disp_val;
  logic [NUM_DIGITS-1:0] disp_dp;
  logic                  pending;

  logic [3:0]            sel_nib;
  logic                  sel_dp;
  logic                  sel_blank;
  logic [NUM_DIGITS-1:0] an_raw;
  logic [NUM_DIGITS-1:0] lead_blank;
  logic [SEG_W-1:0]      font_seg;
  logic [SEG_W-1:0]      seg_raw;

  assign scan_wrap  = (presc == PRE_LAST);
  assign frame_wrap = scan_wrap && (digit_idx == IDX_LAST);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      presc     <= '0;
      digit_idx <= '0;
    end else if (scan_wrap) begin
      presc     <= '0;
      digit_idx <= (digit_idx == IDX_LAST) ? '0 : digit_idx + 1'b1;
    end else begin
      presc     <= presc + 1'b1;
    end
  end

  // The display register only changes at the frame wrap so a frame never mixes old and new digits.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      shadow_val <= '0;
      shadow_dp  <= '0;
      disp_val   <= '0;
      disp_dp    <= '0;
      pending    <= 1'b0;
    end else begin
      if (load) begin
        shadow_val <= value;
        shadow_dp  <= dp_in;
      end
      if (frame_wrap && pending) begin
        disp_val <= shadow_val;
        disp_dp  <= shadow_dp;
      end
      if (load) begin
        pending <= 1'b1;
      end else if (frame_wrap) begin
        pending <= 1'b0;
      end
    end
  end

`ifdef SEVEN_SEG_LZB_EN
  // A digit is blanked when it and every more significant nibble are zero.
  always_comb begin
    lead_blank = '0;
    for (int i = 1; i < NUM_DIGITS; i++) begin
      lead_blank[i] = 1'b1;
      for (int j = i; j < NUM_DIGITS; j++) begin
        if (disp_val[4*j +: 4] != 4'h0) begin
          lead_blank[i] = 1'b0;
        end
      end
    end
  end
`else
  assign lead_blank = '0;
`endif

  always_comb begin
    sel_nib   = '0;
    sel_dp    = 1'b0;
    sel_blank = 1'b0;
    an_raw    = '0;
    for (int i = 0; i < NUM_DIGITS; i++) begin
      if (digit_idx == IDX_W'(i)) begin
        sel_nib   = disp_val[4*i +: 4];
        sel_dp    = disp_dp[i];
        sel_blank = lead_blank[i];
        an_raw[i] = 1'b1;
      end
    end
  end

  seven_seg_font u_font (
    .nibble (sel_nib),
    .seg    (font_seg)
  );

  assign seg_raw = sel_blank ? '0 : font_seg;

  // Polarity is applied only here; everything upstream is active-high.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      seg        <= SEG_OFF;
      dp         <= DP_OFF;
      an         <= AN_OFF;
      frame_tick <= 1'b0;
    end else begin
      seg        <= (SEG_ACTIVE_LOW != 0) ? ~seg_raw : seg_raw;
      dp         <= (SEG_ACTIVE_LOW != 0) ? ~sel_dp : sel_dp;
      if (blank) begin
        an <= AN_OFF;
      end else begin
        an <= (AN_ACTIVE_LOW != 0) ? ~an_raw : an_raw;
      end
      frame_tick <= frame_wrap;
    end
  end

endmodule

// File: tb/tb_seven_seg_scan_driver.sv
// Directed self-checking bench for seven_seg_scan_driver (4 digits, 4 clocks per digit).
// Expectations for digits 2/3 of 16'h0070 depend on SEVEN_SEG_LZB_EN.
module tb_seven_seg_scan_driver;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        load = 1'b0;
  logic [15:0] value = '0;
  logic [3:0]  dp_in = '0;
  logic        blank = 1'b0;
  logic [6:0]  seg;
  logic        dp;
  logic [3:0]  an;
  logic        frame_tick;

  int checks   = 0;
  int failures = 0;
  int edge_cnt = 0;

`ifdef SEVEN_SEG_LZB_EN
  localparam logic [6:0] UPPER_ZERO_SEG = 7'h00;
`else
  localparam logic [6:0] UPPER_ZERO_SEG = 7'h3F;
`endif

  seven_seg_scan_driver #(
    .NUM_DIGITS     (4),
    .SCAN_DIV       (4),
    .SEG_ACTIVE_LOW (0),
    .AN_ACTIVE_LOW  (1)
  ) dut (
    .clk        (clk),
    .reset      (reset),
    .load       (load),
    .value      (value),
    .dp_in      (dp_in),
    .blank      (blank),
    .seg        (seg),
    .dp         (dp),
    .an         (an),
    .frame_tick (frame_tick)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
    edge_cnt++;
  endtask

  task automatic run_to(input int target);
    while (edge_cnt < target) tick();
  endtask

  task automatic check_output(input string tag, input logic [15:0] observed,
                              input logic [15:0] expected);
    checks++;
    assert (observed === expected) else begin
      failures++;
      $error("[TB] FAIL %s observed=%h expected=%h (edge %0d)", tag, observed, expected, edge_cnt);
    end
  endtask

  task automatic apply_stimulus(input logic [15:0] val, input logic [3:0] dpv);
    load  = 1'b1;
    value = val;
    dp_in = dpv;
    tick();
    load  = 1'b0;
  endtask

  initial begin
    // Reset held: all outputs at their off level.
    repeat (3) @(posedge clk);
    #1;
    check_output("rst_an", 16'(an), 16'hF);
    check_output("rst_seg", 16'(seg), 16'h00);
    check_output("rst_dp", 16'(dp), 16'h0);
    check_output("rst_tick", 16'(frame_tick), 16'h0);

    reset = 1'b0;
    edge_cnt = 0;
    run_to(1);
    check_output("first_an", 16'(an), 16'hE);
    check_output("first_seg", 16'(seg), 16'h3F);
    run_to(4);
    check_output("d0_hold_an", 16'(an), 16'hE);
    run_to(5);
    check_output("d1_an", 16'(an), 16'hD);
    run_to(9);
    check_output("d2_an", 16'(an), 16'hB);
    run_to(13);
    check_output("d3_an", 16'(an), 16'h7);
    run_to(15);
    check_output("tick_pre", 16'(frame_tick), 16'h0);
    run_to(16);
    check_output("tick_16", 16'(frame_tick), 16'h1);
    run_to(17);
    check_output("tick_post", 16'(frame_tick), 16'h0);
    check_output("wrap_an", 16'(an), 16'hE);

    // Mid-frame load: old digits until the frame wrap.
    run_to(20);
    apply_stimulus(16'h1A2F, 4'b0100);
    run_to(25);
    check_output("old_d2_seg", 16'(seg), 16'h3F);
    run_to(32);
    check_output("tick_32", 16'(frame_tick), 16'h1);
    check_output("old_d3_seg", 16'(seg), 16'h3F);
    run_to(33);
    check_output("new_d0_seg", 16'(seg), 16'h71);
    check_output("new_d0_an", 16'(an), 16'hE);
    run_to(37);
    check_output("new_d1_seg", 16'(seg), 16'h5B);
    check_output("new_d1_dp", 16'(dp), 16'h0);
    apply_stimulus(16'h1111, 4'b0000);
    run_to(41);
    check_output("new_d2_seg", 16'(seg), 16'h77);
    check_output("new_d2_dp", 16'(dp), 16'h1);
    apply_stimulus(16'h2222, 4'b0000);
    run_to(45);
    check_output("new_d3_seg", 16'(seg), 16'h06);
    check_output("new_d3_an", 16'(an), 16'h7);

    // Last of two loads wins.
    run_to(48);
    check_output("tick_48", 16'(frame_tick), 16'h1);
    run_to(49);
    check_output("lw_d0_seg", 16'(seg), 16'h5B);
    run_to(53);
    check_output("lw_d1_seg", 16'(seg), 16'h5B);
    run_to(57);
    check_output("lw_d2_seg", 16'(seg), 16'h5B);
    run_to(61);
    check_output("lw_d3_seg", 16'(seg), 16'h5B);

    // Load captured on the wrap edge is shown one frame later.
    run_to(63);
    apply_stimulus(16'h3333, 4'b0000);
    check_output("tick_64", 16'(frame_tick), 16'h1);
    run_to(65);
    check_output("edge_load_wait_d0", 16'(seg), 16'h5B);
    run_to(77);
    check_output("edge_load_wait_d3", 16'(seg), 16'h5B);
    run_to(81);
    check_output("edge_load_shown", 16'(seg), 16'h4F);

    // Blank for 10 clocks; scanning keeps running underneath.
    run_to(82);
    blank = 1'b1;
    run_to(83);
    check_output("blank_first", 16'(an), 16'hF);
    run_to(92);
    check_output("blank_last", 16'(an), 16'hF);
    blank = 1'b0;
    run_to(93);
    check_output("unblank_an", 16'(an), 16'h7);
    run_to(96);
    check_output("tick_96", 16'(frame_tick), 16'h1);
    run_to(97);
    check_output("unblank_d0_an", 16'(an), 16'hE);
    check_output("unblank_d0_seg", 16'(seg), 16'h4F);

    // Leading-zero case.
    apply_stimulus(16'h0070, 4'b1000);
    run_to(113);
    check_output("lz_d0_seg", 16'(seg), 16'h3F);
    check_output("lz_d0_dp", 16'(dp), 16'h0);
    run_to(117);
    check_output("lz_d1_seg", 16'(seg), 16'h07);
    run_to(121);
    check_output("lz_d2_seg", 16'(seg), 16'(UPPER_ZERO_SEG));
    run_to(125);
    check_output("lz_d3_seg", 16'(seg), 16'(UPPER_ZERO_SEG));
    check_output("lz_d3_dp", 16'(dp), 16'h1);

    // Mid-frame reset discards a pending load.
    apply_stimulus(16'h5555, 4'b1111);
    run_to(129);
    reset = 1'b1;
    #1;
    check_output("mid_rst_an", 16'(an), 16'hF);
    check_output("mid_rst_seg", 16'(seg), 16'h00);
    check_output("mid_rst_dp", 16'(dp), 16'h0);
    @(posedge clk);
    #1;
    check_output("mid_rst_hold_an", 16'(an), 16'hF);
    check_output("mid_rst_hold_tick", 16'(frame_tick), 16'h0);
    reset = 1'b0;
    edge_cnt = 0;
    run_to(1);
    check_output("rel_an", 16'(an), 16'hE);
    check_output("rel_seg", 16'(seg), 16'h3F);
    run_to(16);
    check_output("rel_tick_16", 16'(frame_tick), 16'h1);
    run_to(17);
    check_output("rel_no_pending_d0", 16'(seg), 16'h3F);
    check_output("rel_no_pending_dp", 16'(dp), 16'h0);
    run_to(21);
    check_output("rel_no_pending_d1", 16'(seg), 16'h3F);
    check_output("rel_d1_an", 16'(an), 16'hD);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
